// File: rtl/slot_sequencer.sv
// slot_sequencer: walks descriptor slots, issues MM2S/S2MM commands for PENDING slots
// and writes back final status plus an ISSUE+WAIT cycle profile.
module slot_sequencer #(
    parameter int NUM_SLOTS       = 4,
    parameter int INPUT_IDX_WIDTH = 2,
    parameter int SRC_ADDR_WIDTH  = 32,
    parameter int SRC_SIZE_WIDTH  = 26,
    parameter int DST_ADDR_WIDTH  = 32,
    parameter int DST_SIZE_WIDTH  = 26,
    parameter int STATUS_WIDTH    = 2,
    parameter int PROFILE_WIDTH   = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [INPUT_IDX_WIDTH-1:0] rd_idx,
    input  logic [SRC_ADDR_WIDTH-1:0]  rd_src_addr,
    input  logic [SRC_SIZE_WIDTH-1:0]  rd_src_size,
    input  logic [DST_ADDR_WIDTH-1:0]  rd_des_addr,
    input  logic [DST_SIZE_WIDTH-1:0]  rd_des_size,
    input  logic [STATUS_WIDTH-1:0]    rd_status,
    output logic [INPUT_IDX_WIDTH-1:0] wr_idx,
    output logic [STATUS_WIDTH-1:0]    wr_status,
    output logic [PROFILE_WIDTH-1:0]   wr_profile,
    output logic                       set_status,
    output logic                       set_profile,
    output logic                       mm2s_cmd_valid,
    input  logic                       mm2s_cmd_ready,
    output logic [SRC_ADDR_WIDTH-1:0]  mm2s_cmd_addr,
    output logic [SRC_SIZE_WIDTH-1:0]  mm2s_cmd_size,
    output logic                       s2mm_cmd_valid,
    input  logic                       s2mm_cmd_ready,
    output logic [DST_ADDR_WIDTH-1:0]  s2mm_cmd_addr,
    output logic [DST_SIZE_WIDTH-1:0]  s2mm_cmd_size,
    input  logic                       mm2s_done,
    input  logic                       s2mm_done,
    input  logic                       dma_err
);
    localparam logic [STATUS_WIDTH-1:0] PENDING = STATUS_WIDTH'(1);
    localparam logic [STATUS_WIDTH-1:0] DONE    = STATUS_WIDTH'(2);
    localparam logic [STATUS_WIDTH-1:0] ERROR   = STATUS_WIDTH'(3);

    typedef enum logic [2:0] {IDLE, LOAD, CHECK, ISSUE, WAIT, WRBACK, NEXT, FINISH} state_t;

    state_t                     state;
    logic [INPUT_IDX_WIDTH-1:0] slot;
    logic [STATUS_WIDTH-1:0]    status;
    logic [PROFILE_WIDTH-1:0]   prof;
    logic                       m_acc, s_acc, m_fin, s_fin;
    logic                       m_acc_n, s_acc_n;
    logic [PROFILE_WIDTH-1:0]   prof_inc;

    // a direction counts as accepted from its handshake cycle onward, so a done
    // pulse coinciding with the handshake is not lost
    assign m_acc_n  = m_acc | (mm2s_cmd_valid & mm2s_cmd_ready);
    assign s_acc_n  = s_acc | (s2mm_cmd_valid & s2mm_cmd_ready);
    assign prof_inc = &prof ? prof : prof + 1'b1;
    assign rd_idx   = slot;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            slot           <= '0;
            status         <= '0;
            prof           <= '0;
            {m_acc, s_acc, m_fin, s_fin} <= '0;
            {busy, done, err, set_status, set_profile} <= '0;
            {mm2s_cmd_valid, s2mm_cmd_valid} <= '0;
            mm2s_cmd_addr  <= '0;
            mm2s_cmd_size  <= '0;
            s2mm_cmd_addr  <= '0;
            s2mm_cmd_size  <= '0;
            wr_idx         <= '0;
            wr_status      <= '0;
            wr_profile     <= '0;
        end else begin
            done        <= 1'b0;
            set_status  <= 1'b0;
            set_profile <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    slot  <= '0;
                    err   <= 1'b0;
                    busy  <= 1'b1;
                    state <= LOAD;
                end
                LOAD: begin
                    mm2s_cmd_addr <= rd_src_addr;
                    mm2s_cmd_size <= rd_src_size;
                    s2mm_cmd_addr <= rd_des_addr;
                    s2mm_cmd_size <= rd_des_size;
                    status        <= rd_status;
                    state         <= CHECK;
                end
                CHECK: if (status != PENDING) state <= NEXT;
                else begin
                    prof           <= '0;
                    mm2s_cmd_valid <= mm2s_cmd_size != '0;
                    s2mm_cmd_valid <= s2mm_cmd_size != '0;
                    m_acc          <= mm2s_cmd_size == '0;
                    m_fin          <= mm2s_cmd_size == '0;
                    s_acc          <= s2mm_cmd_size == '0;
                    s_fin          <= s2mm_cmd_size == '0;
                    state          <= ISSUE;
                end
                ISSUE, WAIT: begin
                    prof  <= prof_inc;
                    m_acc <= m_acc_n;
                    s_acc <= s_acc_n;
                    if (m_acc_n) mm2s_cmd_valid <= 1'b0;
                    if (s_acc_n) s2mm_cmd_valid <= 1'b0;
                    if (mm2s_done && m_acc_n) m_fin <= 1'b1;
                    if (s2mm_done && s_acc_n) s_fin <= 1'b1;
                    if (dma_err || (state == WAIT && m_fin && s_fin)) begin
                        if (dma_err) begin
                            mm2s_cmd_valid <= 1'b0;
                            s2mm_cmd_valid <= 1'b0;
                            err            <= 1'b1;
                        end
                        wr_idx      <= slot;
                        wr_status   <= dma_err ? ERROR : DONE;
                        wr_profile  <= prof_inc;
                        set_status  <= 1'b1;
                        set_profile <= 1'b1;
                        state       <= WRBACK;
                    end else if (state == ISSUE && m_acc_n && s_acc_n) state <= WAIT;
                end
                WRBACK: begin
                    done  <= wr_status == ERROR;
                    state <= wr_status == ERROR ? FINISH : NEXT;
                end
                NEXT: if (slot == INPUT_IDX_WIDTH'(NUM_SLOTS - 1)) begin
                    done  <= 1'b1;
                    state <= FINISH;
                end else begin
                    slot  <= slot + 1'b1;
                    state <= LOAD;
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_slot_sequencer.sv
// tb_slot_sequencer: directed checks of slot walking, DMA handshakes, write-back,
// error abort, asynchronous reset and start-while-busy.
module tb_slot_sequencer;
    logic        clk = 0, reset = 1, start = 0, dma_err = 0;
    logic        busy, done, err, set_status, set_profile;
    logic [1:0]  rd_idx, wr_idx, rd_status, wr_status;
    logic [31:0] rd_src_addr, rd_des_addr, wr_profile, mm2s_cmd_addr, s2mm_cmd_addr;
    logic [25:0] rd_src_size, rd_des_size, mm2s_cmd_size, s2mm_cmd_size;
    logic        mm2s_cmd_valid, mm2s_cmd_ready, s2mm_cmd_valid, s2mm_cmd_ready, mm2s_done, s2mm_done;

    logic [31:0] t_src_addr [4], t_dst_addr [4];
    logic [25:0] t_src_size [4], t_dst_size [4];
    logic [1:0]  t_status [4];

    int m_dly = 1, s_dly = 1, m_stall = 0, s_stall = 0;
    int m_t = 0, s_t = 0, m_vc = 0, s_vc = 0;
    int unstable = 0, strobe_bad = 0;
    logic        m_hold = 0, s_hold = 0;
    logic [57:0] m_hold_v = 0, s_hold_v = 0;
    logic [31:0] m_addr [$], s_addr [$];
    logic [25:0] m_size [$], s_size [$];
    logic [1:0]  wb_idx [$], wb_st [$];
    logic [31:0] wb_prof [$];

    int errs = 0, n = 0;
    logic found;

    slot_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .err(err),
        .rd_idx(rd_idx), .rd_src_addr(rd_src_addr), .rd_src_size(rd_src_size),
        .rd_des_addr(rd_des_addr), .rd_des_size(rd_des_size), .rd_status(rd_status),
        .wr_idx(wr_idx), .wr_status(wr_status), .wr_profile(wr_profile),
        .set_status(set_status), .set_profile(set_profile),
        .mm2s_cmd_valid(mm2s_cmd_valid), .mm2s_cmd_ready(mm2s_cmd_ready),
        .mm2s_cmd_addr(mm2s_cmd_addr), .mm2s_cmd_size(mm2s_cmd_size),
        .s2mm_cmd_valid(s2mm_cmd_valid), .s2mm_cmd_ready(s2mm_cmd_ready),
        .s2mm_cmd_addr(s2mm_cmd_addr), .s2mm_cmd_size(s2mm_cmd_size),
        .mm2s_done(mm2s_done), .s2mm_done(s2mm_done), .dma_err(dma_err)
    );

    always #5 clk = ~clk;

    assign rd_src_addr    = t_src_addr[rd_idx];
    assign rd_src_size    = t_src_size[rd_idx];
    assign rd_des_addr    = t_dst_addr[rd_idx];
    assign rd_des_size    = t_dst_size[rd_idx];
    assign rd_status      = t_status[rd_idx];
    assign mm2s_cmd_ready = m_vc >= m_stall;
    assign s2mm_cmd_ready = s_vc >= s_stall;
    assign mm2s_done      = m_dly == 0 ? (mm2s_cmd_valid && mm2s_cmd_ready) : (m_t == 1);
    assign s2mm_done      = s_dly == 0 ? (s2mm_cmd_valid && s2mm_cmd_ready) : (s_t == 1);

    // DMA model: logs handshakes, stalls ready, schedules done pulses; also logs write-backs
    always @(posedge clk) begin
        if (mm2s_cmd_valid && mm2s_cmd_ready) begin
            m_addr.push_back(mm2s_cmd_addr);
            m_size.push_back(mm2s_cmd_size);
            m_t <= m_dly;
        end else if (m_t > 0) m_t <= m_t - 1;
        if (s2mm_cmd_valid && s2mm_cmd_ready) begin
            s_addr.push_back(s2mm_cmd_addr);
            s_size.push_back(s2mm_cmd_size);
            s_t <= s_dly;
        end else if (s_t > 0) s_t <= s_t - 1;
        m_vc <= (mm2s_cmd_valid && !mm2s_cmd_ready) ? m_vc + 1 : 0;
        s_vc <= (s2mm_cmd_valid && !s2mm_cmd_ready) ? s_vc + 1 : 0;
        if (!reset && ((m_hold && (!mm2s_cmd_valid || {mm2s_cmd_addr, mm2s_cmd_size} !== m_hold_v)) ||
                       (s_hold && (!s2mm_cmd_valid || {s2mm_cmd_addr, s2mm_cmd_size} !== s_hold_v))))
            unstable <= unstable + 1;
        m_hold   <= mm2s_cmd_valid && !mm2s_cmd_ready && !dma_err;
        s_hold   <= s2mm_cmd_valid && !s2mm_cmd_ready && !dma_err;
        m_hold_v <= {mm2s_cmd_addr, mm2s_cmd_size};
        s_hold_v <= {s2mm_cmd_addr, s2mm_cmd_size};
        if (set_status !== set_profile) strobe_bad <= strobe_bad + 1;
        if (set_status) begin
            wb_idx.push_back(wr_idx);
            wb_st.push_back(wr_status);
            wb_prof.push_back(wr_profile);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic go();
        start = 1;
        tick(1);
        start = 0;
    endtask

    task automatic clear_logs();
        m_addr.delete(); m_size.delete(); s_addr.delete(); s_size.delete();
        wb_idx.delete(); wb_st.delete(); wb_prof.delete();
    endtask

    task automatic wait_done(input string tag);
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick(1);
            if (done) found = 1;
        end
        chk({tag, "_done_seen"}, 64'(found), 64'd1);
        tick(1);
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_busy_off"}, 64'(busy), 64'd0);
    endtask

    task automatic wait_cmds(input int k);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick(1);
            if (m_addr.size() >= k) found = 1;
        end
        chk("cmd_wait", 64'(found), 64'd1);
    endtask

    task automatic set_slots(input logic [1:0] s0, s1, s2, s3);
        t_status[0] = s0; t_status[1] = s1; t_status[2] = s2; t_status[3] = s3;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            t_src_addr[i] = 32'h3000 + 32'h100 * i;
            t_dst_addr[i] = 32'h4000 + 32'h100 * i;
            t_src_size[i] = 26'(16 * (i + 1));
            t_dst_size[i] = 26'(8 * (i + 1));
        end
        set_slots(0, 0, 0, 0);
        tick(2);
        chk("rst_ctrl", {busy, done, err, set_status, set_profile, mm2s_cmd_valid, s2mm_cmd_valid}, 0);
        chk("rst_idx", {rd_idx, wr_idx, wr_status}, 0);
        chk("rst_prof", wr_profile, 0);
        reset = 0;
        tick(1);

        // single PENDING slot, immediate ready, done 5 cycles after handshake
        t_src_addr[0] = 32'h1000; t_src_size[0] = 64;
        t_dst_addr[0] = 32'h2000; t_dst_size[0] = 64;
        set_slots(1, 0, 0, 0);
        m_dly = 5; s_dly = 5;
        clear_logs();
        go();
        chk("t1_busy", busy, 1);
        wait_done("t1");
        chk("t1_ncmd", {32'(m_addr.size()), 32'(s_addr.size())}, {32'd1, 32'd1});
        chk("t1_mm2s", {m_addr[0], 32'(m_size[0])}, {32'h1000, 32'd64});
        chk("t1_s2mm", {s_addr[0], 32'(s_size[0])}, {32'h2000, 32'd64});
        chk("t1_nwb", wb_idx.size(), 1);
        chk("t1_wb", {wb_idx[0], wb_st[0], wb_prof[0]}, {2'd0, 2'd2, 32'd7});
        chk("t1_err", err, 0);

        // all PENDING, MM2S ready stalls 3 cycles per command
        for (int i = 0; i < 4; i++) begin
            t_src_addr[i] = 32'h3000 + 32'h100 * i;
            t_src_size[i] = 26'(16 * (i + 1));
        end
        t_dst_addr[0] = 32'h4000; t_dst_size[0] = 8;
        set_slots(1, 1, 1, 1);
        m_stall = 3; m_dly = 2; s_dly = 2;
        clear_logs();
        go();
        wait_done("t2");
        chk("t2_nwb", wb_idx.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_mm2s%0d", i), {m_addr[i], 32'(m_size[i])}, {32'h3000 + 32'h100 * i, 32'(16 * (i + 1))});
            chk($sformatf("t2_s2mm%0d", i), {s_addr[i], 32'(s_size[i])}, {32'h4000 + 32'h100 * i, 32'(8 * (i + 1))});
            chk($sformatf("t2_wb%0d", i), {wb_idx[i], wb_st[i]}, {2'(i), 2'd2});
        end
        chk("t2_prof0", wb_prof[0], 7);
        chk("t2_stable", unstable, 0);

        // zero-size slot: nothing issued, profile 2
        m_stall = 0;
        t_src_size[1] = 0; t_dst_size[1] = 0;
        set_slots(0, 1, 0, 0);
        clear_logs();
        go();
        wait_done("t3");
        chk("t3_ncmd", {32'(m_addr.size()), 32'(s_addr.size())}, 0);
        chk("t3_nwb", wb_idx.size(), 1);
        chk("t3_wb", {wb_idx[0], wb_st[0], wb_prof[0]}, {2'd1, 2'd2, 32'd2});

        // dma_err in WAIT of slot2 aborts the pass
        set_slots(0, 0, 1, 1);
        m_dly = 30; s_dly = 30;
        clear_logs();
        go();
        wait_cmds(1);
        dma_err = 1;
        tick(1);
        dma_err = 0;
        wait_done("t4");
        chk("t4_nwb", wb_idx.size(), 1);
        chk("t4_wb", {wb_idx[0], wb_st[0], wb_prof[0]}, {2'd2, 2'd3, 32'd2});
        chk("t4_err", err, 1);
        chk("t4_ncmd", m_addr.size(), 1);
        tick(35);

        // asynchronous reset during WAIT of slot1, then a fresh pass
        t_src_size[1] = 32; t_dst_size[1] = 32;
        set_slots(1, 1, 0, 0);
        m_dly = 10; s_dly = 10;
        clear_logs();
        go();
        chk("t5_err_clr", err, 0);
        wait_cmds(2);
        reset = 1;
        #1;
        chk("t5_rst_out", {busy, done, mm2s_cmd_valid, s2mm_cmd_valid, set_status, set_profile}, 0);
        tick(1);
        reset = 0;
        tick(12);
        chk("t5_nwb_rst", wb_idx.size(), 1);
        clear_logs();
        go();
        wait_cmds(1);
        chk("t5_first", m_addr[0], 32'h3000);
        wait_done("t5");
        chk("t5_nwb", wb_idx.size(), 2);
        chk("t5_wb1", {wb_idx[1], wb_st[1]}, {2'd1, 2'd2});

        // start while busy ignored; done coincident with handshake
        set_slots(1, 0, 0, 0);
        m_dly = 0; s_dly = 0;
        clear_logs();
        go();
        tick(1);
        chk("t6_busy", busy, 1);
        start = 1;
        tick(1);
        start = 0;
        wait_done("t6");
        chk("t6_wb", {32'(wb_idx.size()), wb_idx[0], wb_st[0], wb_prof[0]}, {32'd1, 2'd0, 2'd2, 32'd2});
        tick(3);
        chk("t6_idle", {busy, 32'(m_addr.size())}, {1'b0, 32'd1});
        chk("strobes_pair", strobe_bad, 0);

        $display("Result: errors=%0d of %0d checks", errs, n);
        $finish;
    end
endmodule
